// File: rtl/elastic_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elastic_arb_pkg
//  Description : Shared constants and helpers for the elastic round-robin
//                arbiter and its grant selector.
//  Revision    : 1.0 - initial release
// ============================================================================
package elastic_arb_pkg;

    // Largest requester count the arbiter is built for
    localparam int unsigned c_max_req = 16;

    // Width of each optional per-requester grant counter
    localparam int unsigned c_stat_cnt_w = 16;

    // Index that follows idx when counting modulo n (n >= 1)
    function automatic int unsigned next_idx(input int unsigned idx,
                                             input int unsigned n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage : elastic_arb_pkg
`default_nettype wire

// File: rtl/rr_grant_sel.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant_sel
//  Description : Purely combinational round-robin selector. Searches valid_i
//                starting at ptr_i, wrapping modulo num_req_p, and reports the
//                first set bit as a one-hot grant and as an index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_sel #(
    parameter int num_req_p   = 4,
    parameter int id_width_lp = $clog2(num_req_p)
) (
    input  logic [num_req_p-1:0]   valid_i,
    input  logic [id_width_lp-1:0] ptr_i,
    output logic [num_req_p-1:0]   grant_o,
    output logic [id_width_lp-1:0] idx_o,
    output logic                   any_o
);

    logic w_found;

    assign any_o = |valid_i;

    // Walk the requesters in priority order (ptr_i first) and keep the first hit
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        w_found = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            if (!w_found && valid_i[(int'(ptr_i) + i) % num_req_p]) begin
                w_found = 1'b1;
                idx_o   = id_width_lp'((int'(ptr_i) + i) % num_req_p);
            end
        end
        if (w_found) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule : rr_grant_sel
`default_nettype wire

// File: rtl/elastic_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : elastic_rr_arbiter
//  Description : Round-robin arbiter feeding a one-entry registered output
//                slot with valid/yumi handshake. Each accepted word is tagged
//                with the index of the requester that sent it.
//                Optional per-requester grant counters are built when the
//                macro ELASTIC_RR_ARBITER_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module elastic_rr_arbiter
    import elastic_arb_pkg::*;
#(
    parameter int   width_p     = 10,
    parameter int   num_req_p   = 4,
    localparam int  id_width_lp = $clog2(num_req_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [num_req_p-1:0]           valid_i,
    input  logic [num_req_p*width_p-1:0]   data_i,
    output logic [num_req_p-1:0]           ready_o,
    output logic                           valid_o,
    output logic [width_p-1:0]             data_o,
    output logic [id_width_lp-1:0]         id_o,
`ifdef ELASTIC_RR_ARBITER_STATS_EN
    output logic [num_req_p*c_stat_cnt_w-1:0] grant_cnt_o,
`endif
    input  logic                           yumi_i
);

    // Requester count outside the supported range is a build error
    if ((num_req_p < 2) || (num_req_p > int'(c_max_req))) begin : g_bad_num_req
        $error("elastic_rr_arbiter: num_req_p out of range");
    end

    // ------------------------------------------------------------------
    // State and combinational signals
    // ------------------------------------------------------------------
    logic                   valid_q, valid_d;
    logic [width_p-1:0]     data_q,  data_d;
    logic [id_width_lp-1:0] id_q,    id_d;
    logic [id_width_lp-1:0] ptr_q,   ptr_d;

    logic [num_req_p-1:0]   w_grant;
    logic [id_width_lp-1:0] w_idx;
    logic                   w_any;
    logic                   w_slot_free;
    logic                   w_accept;
    logic [width_p-1:0]     w_sel_data;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    rr_grant_sel #(
        .num_req_p   (num_req_p),
        .id_width_lp (id_width_lp)
    ) u_grant_sel (
        .valid_i (valid_i),
        .ptr_i   (ptr_q),
        .grant_o (w_grant),
        .idx_o   (w_idx),
        .any_o   (w_any)
    );

    // The slot can take a word when empty or when its word leaves this cycle.
    // A yumi with an empty slot is illegal; valid_q=0 already makes the slot
    // free, so the stray yumi has no effect on slot state.
    assign w_slot_free = ~valid_q | yumi_i;
    assign w_accept    = w_slot_free & w_any;

    // Ready depends only on valid_i, yumi_i and local state, never on a
    // requester's reaction to ready, so no loop is formed. Forced low while
    // reset is held.
    assign ready_o = w_grant & {num_req_p{w_accept & reset_n_i}};

    // Route the granted requester's data slice toward the slot
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < num_req_p; k++) begin
            if (w_grant[k]) begin
                w_sel_data = data_i[k*width_p +: width_p];
            end
        end
    end

    // Next-state of the output slot and the priority pointer
    always_comb begin
        valid_d = w_accept | (valid_q & ~yumi_i);
        data_d  = data_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (w_accept) begin
            data_d = w_sel_data;
            id_d   = w_idx;
            ptr_d  = id_width_lp'(next_idx(32'(w_idx), 32'(num_req_p)));
        end
    end

    // Slot and pointer registers; reset discards any held word
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign id_o    = id_q;

    // ------------------------------------------------------------------
    // Optional grant statistics
    // ------------------------------------------------------------------
`ifdef ELASTIC_RR_ARBITER_STATS_EN
    for (genvar k = 0; k < num_req_p; k++) begin : g_cnt
        logic [c_stat_cnt_w-1:0] cnt_q, cnt_d;

        // Count every accept granted to this requester; wraps naturally
        always_comb begin
            cnt_d = cnt_q;
            if (w_accept && w_grant[k]) begin
                cnt_d = cnt_q + c_stat_cnt_w'(1);
            end
        end

        // Counter register, cleared with the arbiter reset
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign grant_cnt_o[k*c_stat_cnt_w +: c_stat_cnt_w] = cnt_q;
    end
`endif

    // ------------------------------------------------------------------
    // Simulation-only protocol check
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    // Consumer must only take a word while one is held
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(yumi_i && !valid_q));
        end
    end
`endif

endmodule : elastic_rr_arbiter
`default_nettype wire

// File: tb/tb_elastic_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elastic_rr_arbiter
//  Description : Randomised scoreboard bench for elastic_rr_arbiter. A
//                requester-level reference model predicts each accepted word;
//                a separate monitor compares whatever the DUT presents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_elastic_rr_arbiter;

    localparam int W   = 10;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N-1:0]     valid_i;
    logic [N*W-1:0]   data_i;
    logic [N-1:0]     ready_o;
    logic             valid_o;
    logic [W-1:0]     data_o;
    logic [IDW-1:0]   id_o;
    logic             yumi_i;
`ifdef ELASTIC_RR_ARBITER_STATS_EN
    logic [N*16-1:0]  grant_cnt;
`endif

    always #5 clk = ~clk;

    elastic_rr_arbiter #(
        .width_p   (W),
        .num_req_p (N)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .id_o        (id_o),
`ifdef ELASTIC_RR_ARBITER_STATS_EN
        .grant_cnt_o (grant_cnt),
`endif
        .yumi_i      (yumi_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [W-1:0]   d;
        logic [IDW-1:0] id;
    } word_t;
    word_t sb[$];

    // Reference model: requesters, slot occupancy, priority pointer
    int           mptr;
    bit           mvalid;
    bit           pend [N];
    logic [W-1:0] pdata[N];
    int           mlast_g;
    int unsigned  mcnt [N];
    logic [N-1:0] exp_ready;
    bit           exp_valid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: mid-cycle comparison of everything the DUT presents
    always @(negedge clk) begin
        chk("valid_o", 64'(valid_o), 64'(exp_valid));
        chk("ready_o", 64'(ready_o), 64'(exp_ready));
        if (valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard: DUT holds word %0h id %0d, nothing expected", data_o, id_o);
            end else begin
                chk("data_o", 64'(data_o), 64'(sb[0].d));
                chk("id_o",   64'(id_o),   64'(sb[0].id));
                if (yumi_i) void'(sb.pop_front());
            end
        end
    end

    // One clock of stimulus: new requests from 'want', consumer mode
    // 0 = stall, 1 = always take, 2 = random
    task automatic step(input logic [N-1:0] want, input int mode,
                        input bit use_fixed, input logic [W-1:0] fdata);
        bit free;
        bit any;
        int g;
        bit nxt_valid;
        bit y;
        for (int k = 0; k < N; k++) begin
            if (!pend[k] && want[k]) begin
                pend[k]  = 1'b1;
                pdata[k] = use_fixed ? fdata : W'($urandom_range(0, (1 << W) - 1));
            end
        end
        y = mvalid && ((mode == 1) || ((mode == 2) && ($urandom_range(0, 1) == 1)));
        for (int k = 0; k < N; k++) begin
            valid_i[k]        = pend[k];
            data_i[k*W +: W]  = pdata[k];
        end
        yumi_i = y;

        free = !mvalid || y;
        any  = 1'b0;
        for (int k = 0; k < N; k++) any |= pend[k];
        g = -1;
        if (free && any) begin
            for (int i = 0; i < N; i++) begin
                if (g < 0 && pend[(mptr + i) % N]) g = (mptr + i) % N;
            end
        end
        exp_valid = mvalid;
        exp_ready = '0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            sb.push_back('{d: pdata[g], id: IDW'(g)});
            mptr    = (g + 1) % N;
            mlast_g = g;
            mcnt[g] = (mcnt[g] + 1) % 65536;
            pend[g] = 1'b0;
        end
        nxt_valid = (g >= 0) || (mvalid && !y);
        @(posedge clk);
        #2;
        mvalid = nxt_valid;
    endtask

    task automatic model_reset();
        mptr   = 0;
        mvalid = 1'b0;
        sb.delete();
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0;
            mcnt[k] = 0;
        end
        exp_valid = 1'b0;
        exp_ready = '0;
    endtask

    initial begin
        reset_n = 1'b0;
        valid_i = '0;
        data_i  = '0;
        yumi_i  = 1'b0;
        mlast_g = 0;
        for (int k = 0; k < N; k++) pdata[k] = '0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        chk("reset_data_o", 64'(data_o), 64'd0);
        chk("reset_id_o",   64'(id_o),   64'd0);

        // Idle: nothing requested
        repeat (5) step('0, 0, 1'b0, '0);
        chk("idle_id_o", 64'(id_o), 64'd0);

        // Single requester 2 with fixed data, consumer always ready
        repeat (6) step(4'b0100, 1, 1'b1, W'('h155));
        repeat (2) step('0, 1, 1'b0, '0);

        // All requesters, full throughput
        repeat (12) step(4'b1111, 1, 1'b0, '0);

        // Backpressure: slot full, three stalled cycles, then resume
        step(4'b1111, 1, 1'b0, '0);
        repeat (3) step(4'b1111, 0, 1'b0, '0);
        repeat (4) step(4'b1111, 1, 1'b0, '0);

        // Run until the slot holds requester 3's word, then pulse reset
        for (int i = 0; i < 8 && !(mvalid && mlast_g == 3); i++) step(4'b1111, 1, 1'b0, '0);
        chk("pre_reset_id3", 64'(id_o), 64'd3);
        #1;
        reset_n = 1'b0;
        valid_i = '1;
        yumi_i  = 1'b0;
        model_reset();
        #1;
        chk("async_reset_valid_o", 64'(valid_o), 64'd0);
        chk("async_reset_ready_o", 64'(ready_o), 64'd0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        step(4'b1010, 1, 1'b0, '0);
        chk("post_reset_id", 64'(id_o), 64'd1);
        repeat (3) step(4'b1010, 1, 1'b0, '0);

        // Randomised traffic and backpressure
        for (int i = 0; i < 3000; i++) begin
            step(N'($urandom_range(0, (1 << N) - 1)), 2, 1'b0, '0);
        end

`ifdef ELASTIC_RR_ARBITER_STATS_EN
        // Push requester 0's counter through its wrap point
        for (int i = 0; i < 65540; i++) step(4'b0001, 1, 1'b0, '0);
`endif

        // Drain the model and the slot
        for (int i = 0; i < 40; i++) begin
            bit busy;
            busy = mvalid;
            for (int k = 0; k < N; k++) busy |= pend[k];
            if (busy) step('0, 1, 1'b0, '0);
        end
        chk("drained_valid_o", 64'(valid_o), 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

`ifdef ELASTIC_RR_ARBITER_STATS_EN
        for (int k = 0; k < N; k++) begin
            chk($sformatf("grant_cnt[%0d]", k), 64'(grant_cnt[k*16 +: 16]), 64'(mcnt[k]));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_elastic_rr_arbiter
`default_nettype wire
